pp_tree_16x64: RTL and testbench
================================

// Module: pp_tree_16x64
// PURPOSE
//   Wallace-tree carry-save compressor for the single-cycle multiplier datapath.
//   Reduces sixteen 64-bit partial-product rows to one redundant SUM/CARRY pair.
//   The pair resolves to the modulo-2^64 sum of all sixteen rows.
//   Sits between partial-product generation and the final carry-propagate adder.
// PARAMETERS
//   WIDTH  64  Row and output bit width; only 64 is supported and verified.
// PORTS
//   clk        in   1      Single clock; all state updates on the rising edge.
//   rst        in   1      Asynchronous reset, active-high.
//   in_valid   in   1      P0..P15 hold a valid operand set this cycle.
//   P0..P15    in   64 ea  Partial-product rows, already aligned/shifted by the generator.
//   out_valid  out  1      SUM/CARRY hold the result of a valid operand set.
//   SUM        out  64     Redundant sum vector.
//   CARRY      out  64     Redundant carry vector, unshifted.
// BEHAVIOUR
//   - Output relation:
//       (SUM + (CARRY << 1)) mod 2^64 == (P0 + ... + P15) mod 2^64
//     where the right-hand side is the registered set of inputs.
//   - All arithmetic is unsigned and modulo 2^64.
//   - Carries out of bit 63 are discarded at every level.
//     CARRY[63] is therefore don't-care to the consumer, which always shifts CARRY left by 1.
//   - Reduction is a combinational tree of 3:2 full-adder compressors, WIDTH bits wide.
//   - Tree stages: 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 rows (six CSA levels).
//   - At each level, a carry row feeds the next level shifted left by 1 with LSB = 0.
//     Leftover rows that do not fill a 3:2 group pass straight through.
//   - The final two rows go to the output register. The final carry row is stored unshifted in CARRY.
//   - Latency: 1 clock.
//     Inputs sampled on rising edge N appear on SUM/CARRY/out_valid after edge N.
//   - Throughput: one operand set per clock; no back-pressure.
//   - out_valid is in_valid delayed by 1 clock.
//   - SUM/CARRY update every clock regardless of in_valid.
//     Their contents are meaningful only while out_valid = 1.
//   - Reset: while rst = 1, SUM = 0, CARRY = 0 and out_valid = 0, immediately and asynchronously.
//     First capture happens on the first rising edge after rst deasserts.
//   - Reset mid-stream: the in-flight result is lost, and out_valid drops immediately.
//   - No internal state beyond the single output register stage.
// TESTING
//   - Reset:
//       Assert rst with random inputs
//       -> SUM = 0, CARRY = 0, out_valid = 0 without waiting for any clock edge.
//   - All zeros:
//       P0..P15 = 0, in_valid = 1
//       -> one clock later SUM + (CARRY << 1) = 0 and out_valid = 1.
//   - Saturation / wrap:
//       All Pi = 64'hFFFF_FFFF_FFFF_FFFF
//       -> resolved value = 64'hFFFF_FFFF_FFFF_FFF0 (i.e. -16 mod 2^64).
//   - Single row:
//       P7 = 64'h0123_4567_89AB_CDEF, all other rows 0
//       -> resolved value = 64'h0123_4567_89AB_CDEF.
//   - Random:
//       At least 10,000 back-to-back random 64-bit row sets
//       -> each resolved value equals the 64-bit sum of its rows, checked one cycle after input.
//   - Valid pipeline:
//       Toggle in_valid in the pattern 1,0,1,1 -> out_valid follows 1,0,1,1 one cycle later.
//       Additionally assert rst mid-stream -> out_valid drops to 0 immediately.

Source files
------------

// File: rtl/pp_tree_16x64.sv
// pp_tree_16x64
//   Wallace-tree carry-save compressor for the single-cycle multiplier datapath.
//   Sixteen WIDTH-bit partial-product rows are reduced by six levels of 3:2
//   full-adder compressors (16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 rows) to one
//   redundant SUM/CARRY pair, which is registered once. The pair satisfies
//     (SUM + (CARRY << 1)) mod 2^WIDTH == (P0 + ... + P15) mod 2^WIDTH
//   for the operand set captured on the previous rising edge.
//
// Ports
//   clk        in   1      Rising-edge clock.
//   rst        in   1      Asynchronous reset, active-high; clears outputs at once.
//   in_valid   in   1      P0..P15 carry a valid operand set this cycle.
//   P0..P15    in   WIDTH  Partial-product rows, pre-aligned by the generator.
//   out_valid  out  1      in_valid delayed by one clock.
//   SUM        out  WIDTH  Redundant sum vector.
//   CARRY      out  WIDTH  Redundant carry vector, stored unshifted.

module pp_tree_16x64 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] P0,
  input  logic [WIDTH-1:0] P1,
  input  logic [WIDTH-1:0] P2,
  input  logic [WIDTH-1:0] P3,
  input  logic [WIDTH-1:0] P4,
  input  logic [WIDTH-1:0] P5,
  input  logic [WIDTH-1:0] P6,
  input  logic [WIDTH-1:0] P7,
  input  logic [WIDTH-1:0] P8,
  input  logic [WIDTH-1:0] P9,
  input  logic [WIDTH-1:0] P10,
  input  logic [WIDTH-1:0] P11,
  input  logic [WIDTH-1:0] P12,
  input  logic [WIDTH-1:0] P13,
  input  logic [WIDTH-1:0] P14,
  input  logic [WIDTH-1:0] P15,
  output logic             out_valid,
  output logic [WIDTH-1:0] SUM,
  output logic [WIDTH-1:0] CARRY
);

  // ---------------------------------------------------------------------------
  // 3:2 compressor primitives
  // ---------------------------------------------------------------------------

  // Bitwise sum of a full-adder row.
  function automatic logic [WIDTH-1:0] csa_sum(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c);
    return a ^ b ^ c;
  endfunction

  // Bitwise majority (carry) of a full-adder row, unshifted.
  function automatic logic [WIDTH-1:0] csa_maj(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Carry row aligned for the next level: weight doubles, LSB fills with 0 and
  // the carry out of the top bit is dropped (modulo 2^WIDTH arithmetic).
  function automatic logic [WIDTH-1:0] csa_cy(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] maj;
    maj = csa_maj(a, b, c);
    return maj << 1;
  endfunction

  // ---------------------------------------------------------------------------
  // Reduction levels
  // ---------------------------------------------------------------------------

  logic [WIDTH-1:0] l1 [11];
  logic [WIDTH-1:0] l2 [8];
  logic [WIDTH-1:0] l3 [6];
  logic [WIDTH-1:0] l4 [4];
  logic [WIDTH-1:0] l5 [3];

  logic [WIDTH-1:0] sum_d,   sum_q;
  logic [WIDTH-1:0] carry_d, carry_q;
  logic             valid_d, valid_q;

  // Level 1: 16 -> 11. Five compressors consume P0..P14; P15 passes through.
  always_comb begin
    l1[0]  = csa_sum(P0,  P1,  P2);
    l1[1]  = csa_cy (P0,  P1,  P2);
    l1[2]  = csa_sum(P3,  P4,  P5);
    l1[3]  = csa_cy (P3,  P4,  P5);
    l1[4]  = csa_sum(P6,  P7,  P8);
    l1[5]  = csa_cy (P6,  P7,  P8);
    l1[6]  = csa_sum(P9,  P10, P11);
    l1[7]  = csa_cy (P9,  P10, P11);
    l1[8]  = csa_sum(P12, P13, P14);
    l1[9]  = csa_cy (P12, P13, P14);
    l1[10] = P15;
  end

  // Level 2: 11 -> 8. Three compressors, two rows pass through.
  always_comb begin
    l2[0] = csa_sum(l1[0], l1[1], l1[2]);
    l2[1] = csa_cy (l1[0], l1[1], l1[2]);
    l2[2] = csa_sum(l1[3], l1[4], l1[5]);
    l2[3] = csa_cy (l1[3], l1[4], l1[5]);
    l2[4] = csa_sum(l1[6], l1[7], l1[8]);
    l2[5] = csa_cy (l1[6], l1[7], l1[8]);
    l2[6] = l1[9];
    l2[7] = l1[10];
  end

  // Level 3: 8 -> 6. Two compressors, two rows pass through.
  always_comb begin
    l3[0] = csa_sum(l2[0], l2[1], l2[2]);
    l3[1] = csa_cy (l2[0], l2[1], l2[2]);
    l3[2] = csa_sum(l2[3], l2[4], l2[5]);
    l3[3] = csa_cy (l2[3], l2[4], l2[5]);
    l3[4] = l2[6];
    l3[5] = l2[7];
  end

  // Level 4: 6 -> 4. Two compressors, nothing left over.
  always_comb begin
    l4[0] = csa_sum(l3[0], l3[1], l3[2]);
    l4[1] = csa_cy (l3[0], l3[1], l3[2]);
    l4[2] = csa_sum(l3[3], l3[4], l3[5]);
    l4[3] = csa_cy (l3[3], l3[4], l3[5]);
  end

  // Level 5: 4 -> 3. One compressor, one row passes through.
  always_comb begin
    l5[0] = csa_sum(l4[0], l4[1], l4[2]);
    l5[1] = csa_cy (l4[0], l4[1], l4[2]);
    l5[2] = l4[3];
  end

  // Level 6: 3 -> 2. The final carry row is kept unshifted; the consumer
  // applies the shift, so its top bit is don't-care downstream.
  always_comb begin
    sum_d   = csa_sum(l5[0], l5[1], l5[2]);
    carry_d = csa_maj(l5[0], l5[1], l5[2]);
    valid_d = in_valid;
  end

  // ---------------------------------------------------------------------------
  // Output register: the only state in the block.
  // ---------------------------------------------------------------------------

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign SUM       = sum_q;
  assign CARRY     = carry_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_pp_tree_16x64.sv
module tb_pp_tree_16x64;

  typedef struct {
    logic        v;
    logic [63:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] p [16];
  logic        out_valid;
  logic [63:0] sum_o;
  logic [63:0] carry_o;

  exp_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pp_tree_16x64 #(.WIDTH(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .P0       (p[0]),
    .P1       (p[1]),
    .P2       (p[2]),
    .P3       (p[3]),
    .P4       (p[4]),
    .P5       (p[5]),
    .P6       (p[6]),
    .P7       (p[7]),
    .P8       (p[8]),
    .P9       (p[9]),
    .P10      (p[10]),
    .P11      (p[11]),
    .P12      (p[12]),
    .P13      (p[13]),
    .P14      (p[14]),
    .P15      (p[15]),
    .out_valid(out_valid),
    .SUM      (sum_o),
    .CARRY    (carry_o)
  );

  function automatic logic [63:0] resolved();
    return sum_o + (carry_o << 1);
  endfunction

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_rand_rows();
    for (int i = 0; i < 16; i++) p[i] = {$urandom(), $urandom()};
  endtask

  // Drive one operand set between edges, push its expectation, then compare
  // right after the capturing edge.
  task automatic step(input string tag, input logic v);
    exp_t e;
    logic [63:0] acc;
    @(negedge clk);
    in_valid = v;
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc + p[i];
    e.v   = v;
    e.val = acc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_tests++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check1({tag, "_valid"}, out_valid, e.v);
      if (e.v) check64({tag, "_value"}, resolved(), e.val);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    set_rand_rows();
    #1;
    // Reset held from time zero, no edge yet seen.
    check64("reset_sum",   sum_o,   64'h0);
    check64("reset_carry", carry_o, 64'h0);
    check1 ("reset_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check1 ("reset_hold_valid", out_valid, 1'b0);
    check64("reset_hold_sum",   sum_o,     64'h0);
    @(negedge clk);
    rst = 1'b0;

    // All zeros.
    for (int i = 0; i < 16; i++) p[i] = '0;
    step("zeros", 1'b1);

    // Saturation / wrap: 16 * (2^64 - 1) mod 2^64.
    for (int i = 0; i < 16; i++) p[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    step("all_ones", 1'b1);
    check64("all_ones_const", resolved(), 64'hFFFF_FFFF_FFFF_FFF0);

    // Single row in P7.
    for (int i = 0; i < 16; i++) p[i] = '0;
    p[7] = 64'h0123_4567_89AB_CDEF;
    step("single_p7", 1'b1);
    check64("single_p7_const", resolved(), 64'h0123_4567_89AB_CDEF);

    // Walking single row through every position.
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 16; i++) p[i] = '0;
      p[r] = {$urandom(), $urandom()};
      step($sformatf("walk_%0d", r), 1'b1);
    end

    // Top-bit heavy rows exercise discarded carries out of bit 63.
    for (int i = 0; i < 16; i++) p[i] = 64'h8000_0000_0000_0000 | 64'(i);
    step("msb_rows", 1'b1);

    // Valid pipeline 1,0,1,1.
    set_rand_rows(); step("vpat0", 1'b1);
    set_rand_rows(); step("vpat1", 1'b0);
    set_rand_rows(); step("vpat2", 1'b1);
    set_rand_rows(); step("vpat3", 1'b1);

    // Reset mid-stream: outputs clear without an edge.
    set_rand_rows();
    step("pre_rst", 1'b1);
    set_rand_rows();
    rst = 1'b1;
    #1;
    check1 ("midrst_valid", out_valid, 1'b0);
    check64("midrst_sum",   sum_o,     64'h0);
    check64("midrst_carry", carry_o,   64'h0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    set_rand_rows();
    step("post_rst", 1'b1);

    // Back-to-back random sets.
    for (int k = 0; k < 10000; k++) begin
      set_rand_rows();
      step("random", 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
